// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer in front of a byte-wide SRAM controller.
// Port A (read-only) has priority; port B gets starvation protection; a timeout aborts stuck accesses.
module sram_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req_in,
    input  logic [18:0] a_addr_in,
    output logic        a_ack_out,
    output logic [7:0]  a_rdata_out,
    input  logic        b_req_in,
    input  logic        b_rw_in,
    input  logic [18:0] b_addr_in,
    input  logic [7:0]  b_wdata_in,
    output logic        b_ack_out,
    output logic [7:0]  b_rdata_out,
    output logic        mem_trig_out,
    output logic        mem_rw_out,
    output logic [18:0] mem_addr_out,
    output logic [7:0]  mem_wdata_out,
    input  logic        mem_done_in,
    input  logic [7:0]  mem_rdata_in,
    output logic        busy_out,
    output logic        err_out
);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, CAPTURE} state_t;

    state_t        r_state;
    logic          r_owner_b;
    logic [SW-1:0] r_starve;
    logic [TW-1:0] r_tmo;
    logic          r_a_ack;
    logic          r_b_ack;
    logic [7:0]    r_a_rdata;
    logic [7:0]    r_b_rdata;
    logic          r_trig;
    logic          r_rw;
    logic [18:0]   r_addr;
    logic [7:0]    r_wdata;
    logic          r_err;

    logic w_a_el;
    logic w_b_el;
    logic w_starved;
    logic w_grant_a;
    logic w_grant_b;
    logic w_tmo_hit;

    // A request still high during its own ack cycle belongs to the finished transaction.
    assign w_a_el    = a_req_in & ~r_a_ack;
    assign w_b_el    = b_req_in & ~r_b_ack;
    assign w_starved = (r_starve == SW'(STARVE_MAX)) & w_b_el;
    assign w_grant_a = w_a_el & ~w_starved;
    assign w_grant_b = w_b_el & ~w_grant_a;
    assign w_tmo_hit = (r_tmo == TW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_owner_b <= 1'b0;
            r_starve  <= '0;
            r_tmo     <= '0;
            r_a_ack   <= 1'b0;
            r_b_ack   <= 1'b0;
            r_a_rdata <= 8'h00;
            r_b_rdata <= 8'h00;
            r_trig    <= 1'b0;
            r_rw      <= 1'b1;
            r_addr    <= '0;
            r_wdata   <= 8'h00;
            r_err     <= 1'b0;
        end else begin
            r_trig  <= 1'b0;
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_grant_a) begin
                        r_state   <= ISSUE;
                        r_trig    <= 1'b1;
                        r_owner_b <= 1'b0;
                        r_rw      <= 1'b1;
                        r_addr    <= a_addr_in;
                        if (!b_req_in) begin
                            r_starve <= '0;
                        end else if (r_starve != SW'(STARVE_MAX)) begin
                            r_starve <= r_starve + SW'(1);
                        end
                    end else if (w_grant_b) begin
                        r_state   <= ISSUE;
                        r_trig    <= 1'b1;
                        r_owner_b <= 1'b1;
                        r_rw      <= b_rw_in;
                        r_addr    <= b_addr_in;
                        r_wdata   <= b_wdata_in;
                        r_starve  <= '0;
                    end
                end
                ISSUE: begin
                    r_tmo   <= '0;
                    r_state <= WAIT_BUSY;
                end
                WAIT_BUSY, WAIT_DONE: begin
                    r_tmo <= r_tmo + TW'(1);
                    if (w_tmo_hit) begin
                        // Abort: ack the owner with zeroed read data and flag the error.
                        r_state <= IDLE;
                        r_err   <= 1'b1;
                        if (r_owner_b) begin
                            r_b_ack <= 1'b1;
                            if (r_rw) r_b_rdata <= 8'h00;
                        end else begin
                            r_a_ack   <= 1'b1;
                            r_a_rdata <= 8'h00;
                        end
                    end else if (r_state == WAIT_BUSY && !mem_done_in) begin
                        r_state <= WAIT_DONE;
                    end else if (r_state == WAIT_DONE && mem_done_in) begin
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    r_state <= IDLE;
                    if (r_owner_b) begin
                        r_b_ack <= 1'b1;
                        if (r_rw) r_b_rdata <= mem_rdata_in;
                    end else begin
                        r_a_ack   <= 1'b1;
                        r_a_rdata <= mem_rdata_in;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign a_ack_out     = r_a_ack;
    assign a_rdata_out   = r_a_rdata;
    assign b_ack_out     = r_b_ack;
    assign b_rdata_out   = r_b_rdata;
    assign mem_trig_out  = r_trig;
    assign mem_rw_out    = r_rw;
    assign mem_addr_out  = r_addr;
    assign mem_wdata_out = r_wdata;
    assign busy_out      = (r_state != IDLE);
    assign err_out       = r_err;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed vector table, corner sequences, and a
// randomized run scored against a cycle-count transaction model with a byte-memory responder.
module tb_sram_arbiter;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req_in = 1'b0;
    logic [18:0] a_addr_in = '0;
    logic        a_ack_out;
    logic [7:0]  a_rdata_out;
    logic        b_req_in = 1'b0;
    logic        b_rw_in = 1'b1;
    logic [18:0] b_addr_in = '0;
    logic [7:0]  b_wdata_in = '0;
    logic        b_ack_out;
    logic [7:0]  b_rdata_out;
    logic        mem_trig_out;
    logic        mem_rw_out;
    logic [18:0] mem_addr_out;
    logic [7:0]  mem_wdata_out;
    logic        mem_done_in = 1'b1;
    logic [7:0]  mem_rdata_in = 8'h00;
    logic        busy_out;
    logic        err_out;

    sram_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .a_req_in(a_req_in), .a_addr_in(a_addr_in), .a_ack_out(a_ack_out),
        .a_rdata_out(a_rdata_out),
        .b_req_in(b_req_in), .b_rw_in(b_rw_in), .b_addr_in(b_addr_in),
        .b_wdata_in(b_wdata_in), .b_ack_out(b_ack_out), .b_rdata_out(b_rdata_out),
        .mem_trig_out(mem_trig_out), .mem_rw_out(mem_rw_out), .mem_addr_out(mem_addr_out),
        .mem_wdata_out(mem_wdata_out), .mem_done_in(mem_done_in), .mem_rdata_in(mem_rdata_in),
        .busy_out(busy_out), .err_out(err_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          port_b;
        bit          rw;
        logic [18:0] addr;
        logic [7:0]  wd;
        bit          pre;
        logic [7:0]  pre_val;
        logic [7:0]  exp_rd;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] resp_mem [int];
    logic [7:0] ref_mem  [int];
    bit          rs_on = 0, rs_rw = 0, mem_stuck = 0, model_on = 0;
    int          rs_t = 0, rs_lat = 2;
    logic [18:0] rs_addr;
    logic [7:0]  rs_wd;

    int          m_issue, m_ack, m_streak;
    bit          m_own_b, m_rw;
    logic [18:0] m_addr;
    logic [7:0]  m_wd, m_a_rd, m_b_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] rd_resp(input logic [18:0] a);
        return resp_mem.exists(int'(a)) ? resp_mem[int'(a)] : 8'h00;
    endfunction

    function automatic logic [7:0] rd_ref(input logic [18:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
    endfunction

    // Transaction model: each grant issues next cycle, acks 4+latency cycles after issue.
    task automatic model_step();
        bit e_trig, e_aack, e_back, e_busy, a_el, b_el;
        e_trig = (cyc == m_issue);
        e_aack = (cyc == m_ack) && !m_own_b;
        e_back = (cyc == m_ack) && m_own_b;
        e_busy = (cyc >= m_issue) && (cyc < m_ack);
        check("rnd_trig", 32'(mem_trig_out), 32'(e_trig));
        check("rnd_a_ack", 32'(a_ack_out), 32'(e_aack));
        check("rnd_b_ack", 32'(b_ack_out), 32'(e_back));
        check("rnd_busy", 32'(busy_out), 32'(e_busy));
        check("rnd_err", 32'(err_out), 32'(0));
        if (e_trig) begin
            check("rnd_addr", 32'(mem_addr_out), 32'(m_addr));
            check("rnd_rw", 32'(mem_rw_out), 32'(m_rw));
            if (!m_rw) check("rnd_wdata", 32'(mem_wdata_out), 32'(m_wd));
        end
        if (e_aack) check("rnd_a_rdata", 32'(a_rdata_out), 32'(m_a_rd));
        if (e_back) check("rnd_b_rdata", 32'(b_rdata_out), 32'(m_b_rd));
        if (a_ack_out) a_req_in = 1'b0;
        else if (!a_req_in && $urandom_range(0, 2) == 0) begin
            a_req_in  = 1'b1;
            a_addr_in = 19'($urandom_range(0, 7)) << 12;
        end
        if (b_ack_out) b_req_in = 1'b0;
        else if (!b_req_in && $urandom_range(0, 2) == 0) begin
            b_req_in   = 1'b1;
            b_rw_in    = 1'($urandom_range(0, 1));
            b_addr_in  = 19'($urandom_range(0, 7)) << 12;
            b_wdata_in = 8'($urandom);
        end
        if (cyc >= m_ack) begin
            a_el = a_req_in && !(cyc == m_ack && !m_own_b);
            b_el = b_req_in && !(cyc == m_ack && m_own_b);
            if (a_el || b_el) begin
                m_issue = cyc + 1;
                rs_lat  = $urandom_range(1, 4);
                m_ack   = m_issue + 4 + rs_lat;
                if (a_el && !(m_streak == STARVE_MAX && b_el)) begin
                    m_own_b  = 0;
                    m_rw     = 1;
                    m_addr   = a_addr_in;
                    m_a_rd   = rd_ref(a_addr_in);
                    m_streak = b_req_in ? ((m_streak < STARVE_MAX) ? m_streak + 1 : m_streak) : 0;
                end else begin
                    m_own_b  = 1;
                    m_rw     = b_rw_in;
                    m_addr   = b_addr_in;
                    m_wd     = b_wdata_in;
                    m_streak = 0;
                    if (b_rw_in) m_b_rd = rd_ref(b_addr_in);
                    else ref_mem[int'(b_addr_in)] = b_wdata_in;
                end
            end
        end
    endtask

    // One clock: memory responder (done low from trig+2 for rs_lat cycles), then the model.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            rs_on       = 0;
            mem_done_in = 1'b1;
        end else begin
            if (mem_trig_out) begin
                rs_on        = 1;
                rs_t         = cyc;
                rs_addr      = mem_addr_out;
                rs_rw        = mem_rw_out;
                rs_wd        = mem_wdata_out;
                mem_rdata_in = 8'($urandom);
            end
            if (rs_on && !mem_stuck) begin
                if (cyc >= rs_t + 2 && cyc <= rs_t + 1 + rs_lat) mem_done_in = 1'b0;
                else if (cyc == rs_t + 2 + rs_lat) begin
                    mem_done_in = 1'b1;
                    rs_on       = 0;
                    if (rs_rw) mem_rdata_in = rd_resp(rs_addr);
                    else resp_mem[int'(rs_addr)] = rs_wd;
                end
            end
        end
        if (model_on) model_step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_a_ack"}, 32'(a_ack_out), 32'(0));
        check({tag, "_b_ack"}, 32'(b_ack_out), 32'(0));
        check({tag, "_a_rdata"}, 32'(a_rdata_out), 32'(0));
        check({tag, "_b_rdata"}, 32'(b_rdata_out), 32'(0));
        check({tag, "_trig"}, 32'(mem_trig_out), 32'(0));
        check({tag, "_rw"}, 32'(mem_rw_out), 32'(1));
        check({tag, "_addr"}, 32'(mem_addr_out), 32'(0));
        check({tag, "_wdata"}, 32'(mem_wdata_out), 32'(0));
        check({tag, "_busy"}, 32'(busy_out), 32'(0));
        check({tag, "_err"}, 32'(err_out), 32'(0));
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (!busy_out && !a_ack_out && !b_ack_out) ok = 1;
            else tick();
        end
        if (!ok) check({tag, "_idle_timeout"}, 32'(0), 32'(1));
        tick();
    endtask

    // Single isolated transaction with a nominal 2-cycle memory.
    task automatic do_txn(input vec_t v, input string tag);
        int t_issue = -1;
        int n_trig  = 0;
        bit held = 1, stray = 0, got = 0, reissue = 0;
        if (v.pre) resp_mem[int'(v.addr)] = v.pre_val;
        rs_lat = 2;
        if (v.port_b) begin
            b_req_in = 1'b1; b_rw_in = v.rw; b_addr_in = v.addr; b_wdata_in = v.wd;
        end else begin
            a_req_in = 1'b1; a_addr_in = v.addr;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (mem_trig_out) begin
                n_trig++;
                t_issue = cyc;
                check({tag, "_addr"}, 32'(mem_addr_out), 32'(v.addr));
                check({tag, "_rw"}, 32'(mem_rw_out), 32'(v.rw));
                if (!v.rw) check({tag, "_wdata"}, 32'(mem_wdata_out), 32'(v.wd));
            end else if (busy_out && t_issue >= 0) begin
                if (mem_addr_out !== v.addr || mem_rw_out !== v.rw) held = 0;
                if (!v.rw && mem_wdata_out !== v.wd) held = 0;
            end
            if (v.port_b ? a_ack_out : b_ack_out) stray = 1;
            if (v.port_b ? b_ack_out : a_ack_out) begin
                got = 1;
                check({tag, "_latency"}, 32'(cyc - t_issue), 32'(6));
                if (v.port_b) check({tag, "_b_rdata"}, 32'(b_rdata_out), 32'(v.exp_rd));
                else check({tag, "_a_rdata"}, 32'(a_rdata_out), 32'(v.exp_rd));
            end
        end
        a_req_in = 1'b0;
        b_req_in = 1'b0;
        if (!got) check({tag, "_ack_seen"}, 32'(0), 32'(1));
        check({tag, "_held"}, 32'(held), 32'(1));
        check({tag, "_stray_ack"}, 32'(stray), 32'(0));
        check({tag, "_one_trig"}, 32'(n_trig), 32'(1));
        for (int i = 0; i < 2; i++) begin
            tick();
            if (mem_trig_out || a_ack_out || b_ack_out) reissue = 1;
        end
        check({tag, "_quiet_after"}, 32'(reissue), 32'(0));
        if (v.port_b && !v.rw) check({tag, "_mem_written"}, 32'(rd_resp(v.addr)), 32'(v.wd));
    endtask

    initial begin
        vec_t vecs [7];
        vec_t v;
        int   t_issue, t_ack1, t_trig2, n, last_trig, spacing_bad;
        bit   dbl, prev_ack, got, no_ack;
        string order;

        vecs[0] = '{0, 1, 19'h12345, 8'h00, 1, 8'hA5, 8'hA5};
        vecs[1] = '{1, 0, 19'h40001, 8'h3C, 0, 8'h00, 8'h00};
        vecs[2] = '{1, 1, 19'h40001, 8'h00, 0, 8'h00, 8'h3C};
        vecs[3] = '{1, 0, 19'h00010, 8'h77, 0, 8'h00, 8'h3C};
        vecs[4] = '{0, 1, 19'h7FFFF, 8'h00, 1, 8'h5A, 8'h5A};
        vecs[5] = '{1, 1, 19'h00000, 8'h00, 1, 8'hFF, 8'hFF};
        vecs[6] = '{0, 1, 19'h40001, 8'h00, 0, 8'h00, 8'h3C};

        do_reset();
        check_reset_vals("reset");
        for (int i = 0; i < 7; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        // A held high alone: its ack cycle is skipped, so the re-grant issues two cycles later.
        a_req_in = 1'b1; a_addr_in = 19'h02222;
        t_issue = -1; t_ack1 = -1; t_trig2 = -1;
        for (int i = 0; i < 40 && t_trig2 < 0; i++) begin
            tick();
            if (a_ack_out && t_ack1 < 0) t_ack1 = cyc;
            if (mem_trig_out) begin
                if (t_issue < 0) t_issue = cyc;
                else t_trig2 = cyc;
            end
        end
        a_req_in = 1'b0;
        check("hold_a_regrant_gap", 32'(t_trig2 - t_ack1), 32'(2));
        wait_idle("hold_a");

        // Both held: the ack-cycle exclusion hands every other grant to the waiting port.
        a_req_in = 1'b1; a_addr_in = 19'h00100;
        b_req_in = 1'b1; b_rw_in = 1'b0; b_addr_in = 19'h00200; b_wdata_in = 8'h11;
        order = ""; n = 0; last_trig = -1; spacing_bad = 0; dbl = 0; prev_ack = 0;
        for (int i = 0; i < 120 && n < 10; i++) begin
            tick();
            if (mem_trig_out) begin
                order = {order, mem_rw_out ? "A" : "B"};
                if (last_trig >= 0 && cyc - last_trig != 7) spacing_bad++;
                last_trig = cyc;
                n++;
            end
            if ((a_ack_out || b_ack_out) && prev_ack) dbl = 1;
            if (a_ack_out && b_ack_out) dbl = 1;
            prev_ack = a_ack_out || b_ack_out;
        end
        a_req_in = 1'b0;
        b_req_in = 1'b0;
        total++;
        if (order != "ABABABABAB") begin
            bad++;
            $display("FAIL both_held_order: got %s expected ABABABABAB", order);
        end
        check("both_held_spacing", 32'(spacing_bad), 32'(0));
        check("both_held_ack_pulse", 32'(dbl), 32'(0));
        wait_idle("both_held");

        // A drops in its ack cycle while B arrives: B issues next cycle, A is not re-issued.
        resp_mem[32'h333] = 8'h4D;
        a_req_in = 1'b1; a_addr_in = 19'h00333;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            if (a_ack_out) begin
                got = 1;
                check("drop_a_rdata", 32'(a_rdata_out), 32'h4D);
                a_req_in = 1'b0;
                b_req_in = 1'b1; b_rw_in = 1'b0; b_addr_in = 19'h00444; b_wdata_in = 8'h99;
            end
        end
        check("drop_a_ack_seen", 32'(got), 32'(1));
        tick();
        check("drop_b_trig", 32'(mem_trig_out), 32'(1));
        check("drop_b_addr", 32'(mem_addr_out), 32'h444);
        check("drop_b_rw", 32'(mem_rw_out), 32'(0));
        got = 0;
        n = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (mem_trig_out) n++;
            if (b_ack_out) begin got = 1; b_req_in = 1'b0; end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_trig_out) n++;
        end
        b_req_in = 1'b0;
        check("drop_b_ack_seen", 32'(got), 32'(1));
        check("drop_no_reissue", 32'(n), 32'(0));

        // Randomized traffic against the transaction model.
        do_reset();
        resp_mem.delete();
        ref_mem.delete();
        m_issue = -100; m_ack = -100; m_streak = 0; m_own_b = 0;
        m_a_rd = 8'h00; m_b_rd = 8'h00;
        model_on = 1;
        repeat (2500) tick();
        model_on = 0;
        a_req_in = 1'b0;
        b_req_in = 1'b0;
        rs_lat = 2;
        wait_idle("random");

        // Timeout: memory never goes busy; abort acks TIMEOUT+2 after issue with zero data.
        v = '{0, 1, 19'h05555, 8'h00, 1, 8'hC3, 8'hC3};
        do_txn(v, "pre_tmo");
        mem_stuck = 1;
        a_req_in = 1'b1; a_addr_in = 19'h0ABCD;
        t_issue = -1; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (mem_trig_out) t_issue = cyc;
            if (a_ack_out) begin
                got = 1;
                a_req_in = 1'b0;
                check("tmo_latency", 32'(cyc - t_issue), 32'(TIMEOUT + 2));
                check("tmo_rdata", 32'(a_rdata_out), 32'(0));
                check("tmo_err", 32'(err_out), 32'(1));
            end
        end
        a_req_in = 1'b0;
        check("tmo_ack_seen", 32'(got), 32'(1));
        repeat (5) tick();
        check("tmo_err_sticky", 32'(err_out), 32'(1));
        check("tmo_idle", 32'(busy_out), 32'(0));
        mem_stuck = 0;
        rs_on = 0;

        // Reset during WAIT_DONE of an A read drops it without an ack.
        resp_mem[32'h1111] = 8'h6E;
        a_req_in = 1'b1; a_addr_in = 19'h01111;
        t_issue = -1;
        for (int i = 0; i < 10 && t_issue < 0; i++) begin
            tick();
            if (mem_trig_out) t_issue = cyc;
        end
        check("rstmid_trig_seen", 32'(t_issue >= 0), 32'(1));
        tick(); tick(); tick();
        a_req_in = 1'b0;
        rst = 1'b1;
        tick();
        check_reset_vals("rstmid");
        rst = 1'b0;
        no_ack = 1;
        repeat (8) begin
            tick();
            if (a_ack_out || b_ack_out || mem_trig_out) no_ack = 0;
        end
        check("rstmid_no_ack", 32'(no_ack), 32'(1));
        v = '{0, 1, 19'h01111, 8'h00, 0, 8'h00, 8'h6E};
        do_txn(v, "rstmid_fresh");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
